icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache.sv | 94 +++++++++
 tb/tb_icache.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with flip-flop storage.
// Hits return in the request cycle; a miss latches its address and fills one word from memory.

module icache #(
    parameter int          SETS    = 16,
    parameter logic [31:0] PC_INIT = 32'h0
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        halt,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    localparam logic COMPARE = 1'b0;
    localparam logic FILL    = 1'b1;

    logic              state;
    logic              nextstate;
    logic [31:0]       filladdr;

    logic [SETS-1:0]   valid;
    logic [TAG_W-1:0]  tags [SETS];
    logic [31:0]       data [SETS];

    logic [IDX_W-1:0]  reqidx;
    logic [TAG_W-1:0]  reqtag;
    logic [IDX_W-1:0]  fillidx;
    logic [TAG_W-1:0]  filltag;

    logic              tagmatch;
    logic              miss;
    logic              fillwrite;

    // Byte offset and the build-uniformity parameter carry no logic.
    logic              unused_ok;
    assign unused_ok = ^{imemaddr[1:0], PC_INIT};

    assign reqidx  = imemaddr[IDX_W+1:2];
    assign reqtag  = imemaddr[31:IDX_W+2];
    assign fillidx = filladdr[IDX_W+1:2];
    assign filltag = filladdr[31:IDX_W+2];

    assign tagmatch  = valid[reqidx] && (tags[reqidx] == reqtag);
    assign miss      = (state == COMPARE) && imemREN && !tagmatch && !halt;
    assign fillwrite = (state == FILL) && !iwait;

    assign ihit     = (state == COMPARE) && imemREN && tagmatch;
    assign imemload = ihit ? data[reqidx] : 32'h0;
    assign iREN     = (state == FILL);
    assign iaddr    = (state == FILL) ? filladdr : 32'h0;

    always_comb begin
        nextstate = state;
        case (state)
            COMPARE: if (miss)      nextstate = FILL;
            FILL:    if (fillwrite) nextstate = COMPARE;
            default:                nextstate = COMPARE;
        endcase
    end

    // Control state and valid bits; reset abandons any fill in flight.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= COMPARE;
            filladdr <= 32'h0;
            valid    <= '0;
        end else begin
            state <= nextstate;
            if (miss)
                filladdr <= imemaddr;
            if (fillwrite)
                valid[fillidx] <= 1'b1;
        end
    end

    // Tag and data arrays are masked by valid, so they need no reset.
    always_ff @(posedge CLK) begin
        if (fillwrite) begin
            tags[fillidx] <= filltag;
            data[fillidx] <= iload;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Randomized self-checking bench for icache against a behavioural cache model.
// Directed scenarios cover cold miss, hit, conflict, redirect, halt and async reset.

module tb_icache;

    localparam int SETS = 16;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        halt;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    icache #(.SETS(SETS), .PC_INIT(32'h0)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .halt     (halt),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model: one entry per frame, plus the outstanding-fill record.
    bit          mValid [SETS];
    int unsigned mTag   [SETS];
    logic [31:0] mData  [SETS];
    bit          mFilling;
    logic [31:0] mFillAddr;

    int renCycles;

    function automatic int unsigned idxOf(input logic [31:0] a);
        return (a / 4) % SETS;
    endfunction

    function automatic int unsigned tagOf(input logic [31:0] a);
        return a / (4 * SETS);
    endfunction

    function automatic logic [31:0] memData(input logic [31:0] a);
        if (a == 32'h40) return 32'h20010005;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0001;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < SETS; i++) mValid[i] = 1'b0;
        mFilling  = 1'b0;
        mFillAddr = 32'h0;
    endtask

    // One clock cycle: drive at negedge, check settled outputs, advance model, step edge.
    task automatic applyStimulus(input bit ren, input logic [31:0] addr,
                                 input bit hlt, input bit iw);
        bit          expHit;
        logic [31:0] expLoad;
        int unsigned ix;
        imemREN  = ren;
        imemaddr = addr;
        halt     = hlt;
        iwait    = iw;
        iload    = mFilling ? memData(mFillAddr) : $urandom;
        #1;
        ix = idxOf(addr);
        if (mFilling) begin
            expHit  = 1'b0;
            expLoad = 32'h0;
        end else begin
            expHit  = ren && mValid[ix] && (mTag[ix] == tagOf(addr));
            expLoad = expHit ? mData[ix] : 32'h0;
        end
        checkOutput("ihit",     {31'h0, ihit}, {31'h0, expHit});
        checkOutput("imemload", imemload, expLoad);
        checkOutput("iREN",     {31'h0, iREN}, {31'h0, mFilling});
        checkOutput("iaddr",    iaddr, mFilling ? mFillAddr : 32'h0);
        if (iREN) renCycles++;
        if (mFilling) begin
            if (!iw) begin
                mValid[idxOf(mFillAddr)] = 1'b1;
                mTag[idxOf(mFillAddr)]   = tagOf(mFillAddr);
                mData[idxOf(mFillAddr)]  = memData(mFillAddr);
                mFilling = 1'b0;
            end
        end else if (ren && !expHit && !hlt) begin
            mFilling  = 1'b1;
            mFillAddr = addr;
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic fillLine(input logic [31:0] addr, input int waits);
        applyStimulus(1'b1, addr, 1'b0, 1'b1);
        for (int i = 0; i < waits; i++) applyStimulus(1'b1, addr, 1'b0, 1'b1);
        applyStimulus(1'b1, addr, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] ra;
        nRST     = 1'b0;
        imemREN  = 1'b1;
        imemaddr = 32'h40;
        halt     = 1'b0;
        iwait    = 1'b1;
        iload    = 32'h0;
        modelReset();
        #12;
        checkOutput("rst_ihit",     {31'h0, ihit}, 32'h0);
        checkOutput("rst_imemload", imemload, 32'h0);
        checkOutput("rst_iREN",     {31'h0, iREN}, 32'h0);
        checkOutput("rst_iaddr",    iaddr, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;

        // Cold miss: four cycles of iREN, then a same-cycle hit.
        renCycles = 0;
        fillLine(32'h40, 3);
        checkOutput("cold_ren_cycles", renCycles, 32'd4);
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b1);
        checkOutput("cold_hit_data", imemload, 32'h20010005);
        renCycles = 0;
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b1);
        checkOutput("hit_no_ren", renCycles, 32'd0);

        // Conflict eviction on index 0.
        fillLine(32'h80, 1);
        applyStimulus(1'b1, 32'h80, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b1);
        checkOutput("conflict_iREN", {31'h0, iREN}, 32'h1);
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0);

        // Redirect during fill keeps the latched address.
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b1);
        checkOutput("redirect_iaddr", iaddr, 32'h100);
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b0);

        // Halt blocks new misses but lets an in-flight fill finish.
        renCycles = 0;
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 32'h300, 1'b1, 1'b0);
        checkOutput("halt_ren_cycles", renCycles, 32'd0);
        applyStimulus(1'b1, 32'h340, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h340, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h340, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h340, 1'b1, 1'b1);

        // Async reset between edges during a fill.
        applyStimulus(1'b1, 32'h400, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h400, 1'b0, 1'b1);
        #2;
        nRST = 1'b0;
        #1;
        checkOutput("async_iREN",  {31'h0, iREN}, 32'h0);
        checkOutput("async_iaddr", iaddr, 32'h0);
        modelReset();
        @(negedge CLK);
        nRST = 1'b1;
        applyStimulus(1'b1, 32'h400, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h400, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0);

        // Randomized traffic over a small address pool to force conflicts.
        for (int n = 0; n < 3000; n++) begin
            ra = ($urandom_range(0, 3) * 4 * SETS) + ($urandom_range(0, SETS - 1) * 4);
            if ($urandom_range(0, 7) == 0) ra = ra | 32'h8000_0000;
            applyStimulus($urandom_range(0, 9) != 0, ra, $urandom_range(0, 9) == 0,
                          $urandom_range(0, 2) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
